// File: rtl/nand_sipo_collector.sv
// Serial-in/parallel-out collector: assembles WIDTH-bit words MSB-first from the NAND cell output.
// Optional even-parity output enabled by defining NAND_SIPO_PARITY_EN.
module nand_sipo_collector #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   output logic             sin_ready,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] bit_cnt
`ifdef NAND_SIPO_PARITY_EN
   ,
   output logic             dout_parity
`endif
);

   typedef enum logic [1:0] {
      FILL = 2'b00,
      HOLD = 2'b01
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] dout_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             valid_nxt;
   logic             accept;

   assign sin_ready = (state == FILL);
   assign accept    = sin_valid & sin_ready;
   assign shifted   = {sreg[WIDTH-2:0], sin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         sreg       <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         sreg       <= sreg_nxt;
         bit_cnt    <= cnt_nxt;
         dout       <= dout_nxt;
         dout_valid <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = bit_cnt;
      dout_nxt  = dout;
      valid_nxt = dout_valid;
      case (state)
         FILL: begin
            if (accept) begin
               sreg_nxt = shifted;
               if (bit_cnt == LAST_BIT) begin
                  dout_nxt  = shifted;
                  valid_nxt = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = HOLD;
               end else begin
                  cnt_nxt = bit_cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (dout_valid && dout_ready) begin
               valid_nxt = 1'b0;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

`ifdef NAND_SIPO_PARITY_EN
   // Parity tracks dout exactly: captured only on the completing accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_parity <= 1'b0;
      end else if (accept && bit_cnt == LAST_BIT) begin
         dout_parity <= ^shifted;
      end
   end
`endif

endmodule
